// File: rtl/instruction_decode.sv
// instruction_decode: MIPS ID stage with IF/ID register, bypassed register file, branch resolution and load-use stall
//   in : i_clk, i_reset (sync, active-high), i_instruction, i_next_pc_1 from fetch,
//        i_wb_write/i_wb_reg/i_wb_data write-back port, i_ex_mem_read/i_ex_rt load in EX
//   out: o_branch, o_branch_addr, o_stall to fetch (combinational);
//        o_valid, o_rs_data, o_rt_data, o_imm, o_rs, o_rt, o_rd, o_opcode, o_funct ID/EX bundle (registered)
module instruction_decode #(
   parameter int NB_DATA    = 32,
   parameter int NB_ADDRESS = 6,
   parameter int NB_REG     = 5
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [NB_DATA-1:0]    i_instruction,
   input  logic [NB_ADDRESS-1:0] i_next_pc_1,
   input  logic                  i_wb_write,
   input  logic [NB_REG-1:0]     i_wb_reg,
   input  logic [NB_DATA-1:0]    i_wb_data,
   input  logic                  i_ex_mem_read,
   input  logic [NB_REG-1:0]     i_ex_rt,
   output logic                  o_branch,
   output logic [NB_ADDRESS-1:0] o_branch_addr,
   output logic                  o_stall,
   output logic                  o_valid,
   output logic [NB_DATA-1:0]    o_rs_data,
   output logic [NB_DATA-1:0]    o_rt_data,
   output logic [NB_DATA-1:0]    o_imm,
   output logic [NB_REG-1:0]     o_rs,
   output logic [NB_REG-1:0]     o_rt,
   output logic [NB_REG-1:0]     o_rd,
   output logic [5:0]            o_opcode,
   output logic [5:0]            o_funct
);
   typedef struct packed {
      logic                 valid;
      logic [NB_DATA-1:0]   rs_data;
      logic [NB_DATA-1:0]   rt_data;
      logic [NB_DATA-1:0]   imm;
      logic [NB_REG-1:0]    rs;
      logic [NB_REG-1:0]    rt;
      logic [NB_REG-1:0]    rd;
      logic [5:0]           opcode;
      logic [5:0]           funct;
   } idex_t;
   logic [NB_DATA-1:0]    instr_q, instr_d;
   logic [NB_ADDRESS-1:0] pc_q, pc_d;
   logic                  valid_q, valid_d;
   logic [NB_DATA-1:0]    regs_q [2**NB_REG];
   logic [NB_DATA-1:0]    regs_d [2**NB_REG];
   idex_t                 idex_q, idex_d;
   logic [NB_REG-1:0]     rs, rt;
   logic [5:0]            op;
   logic [NB_DATA-1:0]    rs_data, rt_data, imm_ext;
   logic [NB_ADDRESS-1:0] word_off;
   logic                  zext, take;
   always_comb begin
      rs       = instr_q[25:21];
      rt       = instr_q[20:16];
      op       = instr_q[31:26];
      rs_data  = (rs == '0) ? '0 : (i_wb_write && i_wb_reg == rs) ? i_wb_data : regs_q[rs];
      rt_data  = (rt == '0) ? '0 : (i_wb_write && i_wb_reg == rt) ? i_wb_data : regs_q[rt];
      zext     = (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001110);
      imm_ext  = zext ? {{(NB_DATA-16){1'b0}}, instr_q[15:0]} : {{(NB_DATA-16){instr_q[15]}}, instr_q[15:0]};
      // Both the J target and the scaled branch offset are the low instruction bits shifted by two
      word_off = {instr_q[NB_ADDRESS-3:0], 2'b00};
      o_stall  = valid_q && i_ex_mem_read && i_ex_rt != '0 && (i_ex_rt == rs || i_ex_rt == rt);
      take     = valid_q && !o_stall && ((op == 6'b000100 && rs_data == rt_data) ||
                                         (op == 6'b000101 && rs_data != rt_data) ||
                                          op == 6'b000010);
      o_branch      = take;
      o_branch_addr = !take ? '0 : (op == 6'b000010) ? word_off : pc_q + word_off;
   end
   always_comb begin
      instr_d = o_stall ? instr_q : o_branch ? '0 : i_instruction;
      pc_d    = o_stall ? pc_q    : o_branch ? '0 : i_next_pc_1;
      valid_d = o_stall ? valid_q : !o_branch;
      regs_d  = regs_q;
      if (i_wb_write && i_wb_reg != '0) regs_d[i_wb_reg] = i_wb_data;
      idex_d  = '0;
      if (valid_q && !o_stall)
         idex_d = '{valid: 1'b1, rs_data: rs_data, rt_data: rt_data, imm: imm_ext,
                    rs: rs, rt: rt, rd: instr_q[15:11], opcode: op, funct: instr_q[5:0]};
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         instr_q <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
         idex_q  <= '0;
         for (int i = 0; i < 2**NB_REG; i++) regs_q[i] <= '0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         idex_q  <= idex_d;
         regs_q  <= regs_d;
      end
   end
   assign o_valid   = idex_q.valid;
   assign o_rs_data = idex_q.rs_data;
   assign o_rt_data = idex_q.rt_data;
   assign o_imm     = idex_q.imm;
   assign o_rs      = idex_q.rs;
   assign o_rt      = idex_q.rt;
   assign o_rd      = idex_q.rd;
   assign o_opcode  = idex_q.opcode;
   assign o_funct   = idex_q.funct;
endmodule
